// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Single-port memory that answers CPU core accesses with a fixed number of
// wait states followed by a one-cycle ack pulse. After the ack the block
// waits in HOLD until the core drops its request, so accesses never overlap.
//
// Ports
//   clk_i    : clock, all state changes on the rising edge
//   rst_ni   : synchronous active-low reset
//   req_i    : access request, held high by the core until ack is seen
//   we_i     : 1 = write, 0 = read (qualified by req_i)
//   addr_i   : word address (qualified by req_i)
//   wdata_i  : write data (qualified by req_i and we_i)
//   ack_o    : single-cycle completion pulse
//   rdata_o  : read data, meaningful while ack_o is high for a read
//   err_o    : out-of-range access flag, meaningful while ack_o is high
//   busy_o   : high from acceptance until the FSM is back in IDLE
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DepthVal = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              enterAck;
  logic [ADDR_W-1:0] accAddr;
  logic              accWe;
  logic [DATA_W-1:0] accWdata;
  logic              inRange;
  logic [IdxW-1:0]   memIdx;

  // With zero wait states the access completes on the acceptance edge
  // itself, before the latched copies exist, so the live inputs are used
  // while in IDLE and the latched copies everywhere else.
  always_comb begin
    accAddr  = addr_q;
    accWe    = we_q;
    accWdata = wdata_q;
    if (state_q == IDLE) begin
      accAddr  = addr_i;
      accWe    = we_i;
      accWdata = wdata_i;
    end
    inRange = ({1'b0, accAddr} < DepthVal);
    memIdx  = accAddr[IdxW-1:0];
  end

  // Next-state logic. enterAck marks the edge on which the memory access
  // actually happens (write commit / read capture).
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    enterAck  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          waitCnt_d = WaitInit;
          if (WAIT_CYCLES == 0) begin
            state_d  = ACK;
            enterAck = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        waitCnt_d = waitCnt_q - 4'd1;
        if (waitCnt_q == 4'd1) begin
          state_d  = ACK;
          enterAck = 1'b1;
        end
      end
      ACK: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!req_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, wait counter and response registers. Reset aborts any access in
  // flight; rdata is cleared here but memory contents are left alone.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if (enterAck) begin
        err_q <= !inRange;
        if (!accWe) begin
          rdata_q <= inRange ? mem[memIdx] : '0;
        end
      end
    end
  end

  // Request capture on acceptance; later changes on the bus are ignored
  // because these only load while IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state_q == IDLE && req_i) begin
      addr_q  <= addr_i;
      we_q    <= we_i;
      wdata_q <= wdata_i;
    end
  end

  // Memory array, never reset. The write is gated by rst_ni so an access
  // aborted on the same edge can never commit.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enterAck && accWe && inRange) begin
      mem[memIdx] <= accWdata;
    end
  end

  // err is only reported during the ack pulse.
  always_comb begin
    ack_o   = (state_q == ACK);
    err_o   = (state_q == ACK) && err_q;
    rdata_o = rdata_q;
    busy_o  = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Scoreboard bench for mem_responder. Two instances are exercised: dut0 with
// two wait states and dut1 with zero wait states. Each access pushes its
// expected response (data, err, ack cycle) into a per-instance queue; a
// monitor per instance pops and compares whenever ack is seen.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       isRead;
    int         ackCycle;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, ack0, err0, busy0;
  logic [7:0] addr0, wdata0, rdata0;
  logic       req1, we1, ack1, err1, busy1;
  logic [7:0] addr1, wdata1, rdata1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic monOn = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(W0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .busy_o(busy0)
  );

  mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(W1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
  );

  // Free-running clock and an edge counter used to time the ack pulse.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scoreAck(input exp_t e, input logic [7:0] rd, input logic er, input string tag);
    checkOutput({tag, " ackCycle"}, cyc, e.ackCycle);
    checkOutput({tag, " err"}, {31'd0, er}, {31'd0, e.err});
    if (e.isRead) begin
      checkOutput({tag, " rdata"}, {24'd0, rd}, {24'd0, e.rdata});
    end
  endtask

  // Monitor for dut0: every ack must match the head of the queue, and err
  // must stay low outside ack.
  always @(negedge clk) begin
    if (monOn) begin
      if (ack0 === 1'b1) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut0 unexpectedAck: got ack=1 at cycle %0d, expected none", cyc);
        end else begin
          scoreAck(q0.pop_front(), rdata0, err0, "dut0");
        end
      end else begin
        checkOutput("dut0 errOutsideAck", {31'd0, err0}, 32'd0);
      end
    end
  end

  // Same monitor for dut1.
  always @(negedge clk) begin
    if (monOn) begin
      if (ack1 === 1'b1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut1 unexpectedAck: got ack=1 at cycle %0d, expected none", cyc);
        end else begin
          scoreAck(q1.pop_front(), rdata1, err1, "dut1");
        end
      end else begin
        checkOutput("dut1 errOutsideAck", {31'd0, err1}, 32'd0);
      end
    end
  end

  function automatic logic ackOf(input int sel);
    return (sel == 0) ? ack0 : ack1;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  task automatic setInputs(input int sel, input logic r, input logic w,
                           input logic [7:0] a, input logic [7:0] d);
    if (sel == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // One complete access. mode 0 = normal, 1 = drop req right after
  // acceptance, 2 = scramble addr/wdata right after acceptance.
  // hold = extra cycles req stays high once the FSM is in HOLD.
  task automatic applyStimulus(input int sel, input logic w, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] expRd,
                               input logic expErr, input int hold, input int mode);
    exp_t e;
    logic got;
    string tag;
    tag = (sel == 0) ? "dut0" : "dut1";
    @(negedge clk);
    checkOutput({tag, " idleBeforeReq"}, {31'd0, busyOf(sel)}, 32'd0);
    setInputs(sel, 1'b1, w, a, d);
    e.rdata    = expRd;
    e.err      = expErr;
    e.isRead   = !w;
    e.ackCycle = cyc + 1 + ((sel == 0) ? W0 : W1);
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checkOutput({tag, " busyAfterAccept"}, {31'd0, busyOf(sel)}, 32'd1);
        if (mode == 1) setInputs(sel, 1'b0, w, a, d);
        if (mode == 2) setInputs(sel, 1'b1, w, a + 8'd1, ~d);
      end
      if (ackOf(sel) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, " ackSeen"}, {31'd0, got}, 32'd1);
    @(negedge clk);
    checkOutput({tag, " busyInHold"}, {31'd0, busyOf(sel)}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, " busyHeldReq"}, {31'd0, busyOf(sel)}, 32'd1);
    end
    setInputs(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput({tag, " busyAfterRelease"}, {31'd0, busyOf(sel)}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    setInputs(0, 1'b0, 1'b0, 8'h00, 8'h00);
    setInputs(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("reset ack0", {31'd0, ack0}, 32'd0);
    checkOutput("reset busy0", {31'd0, busy0}, 32'd0);
    checkOutput("reset err0", {31'd0, err0}, 32'd0);
    checkOutput("reset rdata0", {24'd0, rdata0}, 32'd0);
    checkOutput("reset ack1", {31'd0, ack1}, 32'd0);
    checkOutput("reset busy1", {31'd0, busy1}, 32'd0);
    checkOutput("reset rdata1", {24'd0, rdata1}, 32'd0);
    rst_n = 1'b1;
    monOn = 1'b1;

    // dut0: two wait states
    applyStimulus(0, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 0, 0);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 0, 0);
    applyStimulus(0, 1'b1, 8'h00, 8'h42, 8'h00, 1'b0, 0, 0);
    applyStimulus(0, 1'b1, 8'h80, 8'hFF, 8'h00, 1'b1, 0, 0);
    applyStimulus(0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 0, 0);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 8'h42, 1'b0, 0, 0);
    applyStimulus(0, 1'b1, 8'h05, 8'h11, 8'h00, 1'b0, 0, 0);
    applyStimulus(0, 1'b0, 8'h05, 8'h00, 8'h11, 1'b0, 0, 0);

    // Reset while the write of 0x33 is still waiting: no ack, no commit.
    @(negedge clk);
    setInputs(0, 1'b1, 1'b1, 8'h05, 8'h33);
    @(negedge clk);
    checkOutput("dut0 busyInWait", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("dut0 busyAfterReset", {31'd0, busy0}, 32'd0);
    checkOutput("dut0 ackAfterReset", {31'd0, ack0}, 32'd0);
    checkOutput("dut0 rdataAfterReset", {24'd0, rdata0}, 32'd0);
    rst_n = 1'b1;
    setInputs(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    applyStimulus(0, 1'b0, 8'h05, 8'h00, 8'h11, 1'b0, 0, 0);

    // Held request, input scrambling after acceptance, early req drop.
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 5, 0);
    applyStimulus(0, 1'b1, 8'h21, 8'h77, 8'h00, 1'b0, 0, 0);
    applyStimulus(0, 1'b1, 8'h20, 8'hC3, 8'h00, 1'b0, 0, 2);
    applyStimulus(0, 1'b0, 8'h20, 8'h00, 8'hC3, 1'b0, 0, 0);
    applyStimulus(0, 1'b0, 8'h21, 8'h00, 8'h77, 1'b0, 0, 0);
    applyStimulus(0, 1'b0, 8'h20, 8'h00, 8'hC3, 1'b0, 0, 1);

    // dut1: zero wait states
    applyStimulus(1, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 0, 0);
    applyStimulus(1, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 0, 0);
    applyStimulus(1, 1'b1, 8'h91, 8'h5A, 8'h00, 1'b1, 0, 0);
    applyStimulus(1, 1'b0, 8'h90, 8'h00, 8'h00, 1'b1, 2, 0);

    repeat (5) @(negedge clk);
    checkOutput("dut0 queueDrained", q0.size(), 32'd0);
    checkOutput("dut1 queueDrained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 8: data bus width in bits.
REQ-002 Parameter ADDR_W, default 8: address bus width in bits.
REQ-003 Parameter DEPTH, default 128: number of implemented words, at addresses 0..DEPTH-1.
REQ-004 Parameter WAIT_CYCLES, default 2: wait states inserted before ack, legal range 0..15.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-007 req  input  1  access request from the CPU core; held high until ack is seen.
REQ-008 we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 addr  input  ADDR_W  word address; qualified by req.
REQ-010 wdata  input  DATA_W  write data; qualified by req and we.
REQ-011 ack  output  1  single-cycle completion pulse.
REQ-012 rdata  output  DATA_W  read data; valid only while ack=1 for a read.
REQ-013 err  output  1  access-error flag; valid only while ack=1.
REQ-014 busy  output  1  high from acceptance until the FSM returns to IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, ACK and HOLD.
REQ-016 In IDLE with req=1 at edge N: latch addr, we and wdata; load the wait counter with WAIT_CYCLES; go to WAIT, or to ACK if WAIT_CYCLES=0.
REQ-017 In WAIT: decrement the counter each edge; go to ACK on the edge where the counter reaches 0.
REQ-018 Latency: ack SHALL be high in exactly one cycle, the cycle following edge N+WAIT_CYCLES.
REQ-019 In ACK: always go to HOLD on the next edge.
REQ-020 In HOLD: stay while req=1; go to IDLE on the first edge with req=0.
REQ-021 Back-to-back requests SHALL need at least one cycle of req=0; accesses are never overlapped.
REQ-022 Changes on addr, we or wdata after acceptance SHALL be ignored.
REQ-023 req falling before ack SHALL NOT abort the access; ack still pulses and the FSM then passes through HOLD to IDLE.
REQ-024 Address range: an access with latched addr >= DEPTH is an error.
  - err=1 during ack.
  - A write is discarded.
  - A read returns rdata = all zeros.
REQ-025 A valid write SHALL commit to memory on the edge entering ACK.
REQ-026 A valid read SHALL present mem[addr] on rdata during the ack cycle, registered on entry to ACK.
REQ-027 A read issued after a write to the same address SHALL return the new data.
REQ-028 Outside ack, rdata SHALL hold its last value and err SHALL be 0.
REQ-029 busy SHALL be 1 in WAIT, ACK and HOLD, and 0 in IDLE.
REQ-030 The wait counter is 4 bits; there is no wrap-around because the counter is reloaded on every acceptance.

Reset
REQ-031 rst=0 at a rising edge SHALL force: state=IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0.
REQ-032 Reset mid-access (WAIT or ACK) SHALL abort the access.
  - No ack is produced afterwards.
  - A write not yet committed is never committed.
REQ-033 Memory contents SHALL NOT be cleared by reset; reads of never-written locations return unknown data.
REQ-034 While rst=0, req SHALL be ignored; the first acceptance is possible at the first edge with rst=1.

Verification
REQ-035 Write then read, WAIT_CYCLES=2:
  - Write 0x5A to addr 0x10, req rises before edge N -> ack high only after edge N+2; busy 1 from N+1.
  - Read addr 0x10 -> rdata=0x5A, err=0.
REQ-036 Zero wait states, WAIT_CYCLES=0: read accepted at edge N -> ack in the cycle directly after edge N.
REQ-037 Out of range: write 0xFF to addr 0x80 (DEPTH=128) -> ack with err=1, memory unchanged; read addr 0x80 -> rdata=0x00, err=1.
REQ-038 Held req: req held high for 5 cycles after ack -> exactly one ack pulse; FSM stays in HOLD; busy=1 until the cycle after req falls.
REQ-039 Reset mid-access:
  - Write 0x33 to addr 0x05 (old value 0x11); rst=0 for one edge while in WAIT -> no ack, busy=0.
  - A subsequent read of addr 0x05 -> 0x11.
REQ-040 Input change after acceptance: change addr and wdata one cycle after acceptance -> the originally latched values are used, as confirmed by read-back.
